result_reader: RTL

RESULT_READER -- requirements
Module: result_reader

---
 rtl/result_pkg.sv | 27 ++
 rtl/result_reader_if.sv | 24 ++
 rtl/result_tx_reg.sv | 30 +++
 rtl/result_reader.sv | 129 ++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared types and widths for the result reader: FSM state encoding, memory geometry, header default.
// RESULT_CHECKSUM_EN adds the CSUM state to the encoding.
package result_pkg;

  localparam int MEM_AW = 13;
  localparam int MEM_DW = 8;
  localparam logic [MEM_DW-1:0] HDR_BYTE_DEF = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR     = 3'd1,
    ST_RD_REQ  = 3'd2,
    ST_RD_WAIT = 3'd3,
    ST_SEND    = 3'd4,
    ST_FIN     = 3'd5
`ifdef RESULT_CHECKSUM_EN
    , ST_CSUM  = 3'd6
`endif
  } state_t;

  // Result address wraps modulo the 13-bit memory space.
  function automatic logic [MEM_AW-1:0] res_addr(input logic [MEM_AW-1:0] base,
                                                  input logic [7:0]        idx);
    return base + MEM_AW'(idx);
  endfunction

endpackage

// File: rtl/result_reader_if.sv
// Bundles the start/status, memory read and byte-stream signals of the result reader.
interface result_reader_if;

  logic                          start;
  logic                          mem_re;
  logic [result_pkg::MEM_AW-1:0] mem_raddr;
  logic [result_pkg::MEM_DW-1:0] mem_dout;
  logic [result_pkg::MEM_DW-1:0] tx_data;
  logic                          tx_valid;
  logic                          tx_ready;
  logic                          busy;
  logic                          done;

  modport master (
    input  start, mem_dout, tx_ready,
    output mem_re, mem_raddr, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, mem_dout, tx_ready,
    input  mem_re, mem_raddr, tx_data, tx_valid, busy, done
  );

endinterface

// File: rtl/result_tx_reg.sv
// Outgoing byte register: holds tx_data/tx_valid until the sink accepts the byte.
module result_tx_reg
  import result_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [MEM_DW-1:0] load_data,
  input  logic              tx_ready,
  output logic [MEM_DW-1:0] tx_data,
  output logic              tx_valid,
  output logic              accept
);

  assign accept = tx_valid & tx_ready;

  // A load in the accept cycle replaces the byte back-to-back (checksum after last data byte).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_valid <= 1'b0;
    end else if (load) begin
      tx_data  <= load_data;
      tx_valid <= 1'b1;
    end else if (accept) begin
      tx_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/result_reader.sv
// Result reader: sends a header byte, N_RES bytes read from memory, then finishes with a done pulse.
// Optional macro RESULT_CHECKSUM_EN appends HDR_BYTE XOR all data bytes before finishing.
module result_reader
  import result_pkg::*;
#(
  parameter int                N_RES     = 8,
  parameter logic [MEM_AW-1:0] BASE_ADDR = 13'd1,
  parameter logic [MEM_DW-1:0] HDR_BYTE  = HDR_BYTE_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  result_reader_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(N_RES - 1);

  state_t            state_reg, state_next;
  logic [7:0]        idx_reg, idx_next;
  logic [MEM_AW-1:0] raddr_reg, raddr_next;
  logic              load;
  logic [MEM_DW-1:0] load_data;
  logic              accept;
  logic [MEM_DW-1:0] tx_data;
  logic              tx_valid;
`ifdef RESULT_CHECKSUM_EN
  logic [MEM_DW-1:0] csum_reg, csum_next;
`endif

  result_tx_reg u_tx (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .tx_ready  (bus.tx_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .accept    (accept)
  );

  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    raddr_next = raddr_reg;
    load       = 1'b0;
    load_data  = HDR_BYTE;
`ifdef RESULT_CHECKSUM_EN
    csum_next  = csum_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (bus.start) begin
          state_next = ST_HDR;
          idx_next   = '0;
`ifdef RESULT_CHECKSUM_EN
          csum_next  = '0;
`endif
          load       = 1'b1;
          load_data  = HDR_BYTE;
        end
      end
      ST_HDR: begin
        if (accept) begin
          state_next = ST_RD_REQ;
          raddr_next = res_addr(BASE_ADDR, idx_reg);
        end
      end
      ST_RD_REQ: state_next = ST_RD_WAIT;
      ST_RD_WAIT: begin
        load       = 1'b1;
        load_data  = bus.mem_dout;
        state_next = ST_SEND;
      end
      ST_SEND: begin
        if (accept) begin
          idx_next = idx_reg + 8'd1;
`ifdef RESULT_CHECKSUM_EN
          csum_next = csum_reg ^ tx_data;
`endif
          if (idx_reg == LAST_IDX) begin
`ifdef RESULT_CHECKSUM_EN
            state_next = ST_CSUM;
            load       = 1'b1;
            load_data  = HDR_BYTE ^ csum_reg ^ tx_data;
`else
            state_next = ST_FIN;
`endif
          end else begin
            state_next = ST_RD_REQ;
            raddr_next = res_addr(BASE_ADDR, idx_next);
          end
        end
      end
`ifdef RESULT_CHECKSUM_EN
      ST_CSUM: begin
        if (accept) state_next = ST_FIN;
      end
`endif
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      raddr_reg <= '0;
`ifdef RESULT_CHECKSUM_EN
      csum_reg  <= '0;
`endif
    end else begin
      state_reg <= state_next;
      idx_reg   <= idx_next;
      raddr_reg <= raddr_next;
`ifdef RESULT_CHECKSUM_EN
      csum_reg  <= csum_next;
`endif
    end
  end

  // Status strobes decode straight from the state register, so reset clears them at once.
  assign bus.mem_re    = (state_reg == ST_RD_REQ);
  assign bus.mem_raddr = raddr_reg;
  assign bus.busy      = (state_reg != ST_IDLE);
  assign bus.done      = (state_reg == ST_FIN);
  assign bus.tx_data   = tx_data;
  assign bus.tx_valid  = tx_valid;

endmodule
